wall_map: RTL and testbench
===========================

Name: wall_map

Overview:
- Tile-map store and sequencer that sits directly upstream of the wall sprite renderer.
- For every pixel spot it looks up the 32x32 tile under the spot and drives the renderer's tile origin (wall_centerX/Y) and sprite_num, registered one cycle later.
- After reset it fills the 20x15 arena: border, pillars and bricks.
- It services brick-destroy requests from the explosion logic and steps a crumbling animation once every ANIM_DIV frames.

Parameters:
- COLS, 20, tiles per row (640 px / 32)
- ROWS, 15, tile rows (480 px / 32)
- ANIM_DIV, 8, frame_tick pulses per crumble animation step

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- spotX  in  11 signed  current pixel X
- spotY  in  11 signed  current pixel Y
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- destroy_req  in  1  explosion asks to hit a tile; held until destroy_ack
- destroy_col  in  5  tile column, stable while destroy_req=1
- destroy_row  in  4  tile row, stable while destroy_req=1
- destroy_ack  out  1  one-cycle pulse, request serviced
- destroy_hit  out  1  valid with ack: 1 means the tile blocked the blast
- wall_centerX  out  10  tile origin X = 32*col
- wall_centerY  out  10  tile origin Y = 32*row
- sprite_num  out  4  sprite code of the tile under the spot
- init_done  out  1  map filled, render data valid

Behaviour:
- Tile codes: 0 empty, 1 fixed wall, 2 brick, 3..6 crumble frames; 7..15 are never written.
- Storage: COLS*ROWS x 4-bit RAM, address row*COLS+col.
  - Synchronous read port, dedicated to rendering.
  - One read/write port, owned by the FSM.
- Render path:
  - Spot is in range when 0<=spotX<640 and 0<=spotY<480; then col=spotX[9:5], row=spotY[8:5].
  - wall_centerX, wall_centerY and sprite_num are all registered and change exactly 1 clk after spotX/spotY. Latency is 1 with no bubbles.
  - Out of range, or init_done=0: sprite_num=0, wall_centerX=0, wall_centerY=0.
- Reset values: destroy_ack=0, destroy_hit=0, init_done=0, outputs 0, anim divider=0, anim_pending=0, FSM=INIT, address=0.
- Asserting reset_n low at any time, including mid-sweep or mid-destroy, aborts the operation and refills the map from scratch.
- FSM states:
  - INIT: writes one tile per cycle, addresses 0..299.
    - code 1 if row==0, row==14, col==0, col==19, or (col and row both even);
    - else code 0 if spawn zone, i.e. (col-1)+(row-1)<=2 or (18-col)+(13-row)<=2;
    - else code 2 if col[0]^row[0]==1;
    - else 0.
    - After address 299: init_done=1 (stays 1 until reset), go to IDLE.
  - IDLE: if destroy_req, go to D_RD. Else if anim_pending, clear anim_pending, set addr=0, go to A_RD. Destroy has priority.
  - D_RD: issue read of the requested tile.
    - If destroy_col>=20 or destroy_row>=15, skip the read and go to D_WR with hit forced to 1 and no write.
  - D_WR: data valid; pulse destroy_ack.
    - Code 0: hit=0, no write.
    - Code 1: hit=1, no write.
    - Code 2: hit=1, write 3.
    - Codes 3..6: hit=1, no write, animation unchanged.
    - Go to D_GAP.
  - D_GAP: one idle cycle with destroy_req ignored; go to IDLE. The requester drops req on the edge after it sees ack.
  - A_RD: read addr.
  - A_WR: codes 3,4,5 are written +1; code 6 is written 0; others untouched. If addr==299 go to IDLE, else addr+1 and go to A_RD. One sweep takes 600 cycles and fits in blanking.
- Anim divider:
  - Counts frame_tick pulses in every state.
  - At count ANIM_DIV-1 it wraps to 0 and sets anim_pending.
  - A second divided tick while anim_pending is already 1 is dropped, not queued.
- A destroy_req arriving during INIT or a sweep waits, holding req, until IDLE.
- A tile destroyed during a sweep, at an address the sweep has already passed, advances at the next sweep.
- Render port reads concurrently with FSM writes. A same-address same-cycle collision returns old data; a one-pixel glitch is acceptable.

Test Plan:
- Reset release → init_done rises exactly 300 clk later. Map dump:
  - (0,0)=1, (2,2)=1, (3,2)=2;
  - (1,1), (2,1), (1,2)=0 (spawn);
  - (18,13)=0, (19,14)=1.
- Render latency: spot (100,70) at cycle n → at n+1: wall_centerX=96, wall_centerY=64, sprite_num=code of (3,2)=2. Spot (-5,10) and (640,10) → sprite_num=0, centers 0.
- Destroy brick (3,2) → ack with hit=1, tile=3. Repeat on (3,2) → hit=1, tile stays 3. Destroy (1,1) → hit=0. Destroy (25,3) → hit=1, no write.
- With ANIM_DIV=8: 8 frame_ticks per step; tile (3,2) goes 3→4→5→6→0 after 32 ticks, then a destroy returns hit=0.
- destroy_req asserted in the 3rd cycle of a sweep → ack delayed until the sweep ends (~600 clk). Sweep result is unaffected. Exactly one ack.
- reset_n pulsed low mid-sweep with tile (3,2)=4 → outputs 0 immediately; after refill (3,2)=2 and init_done is reasserted 300 clk after release.

Source files
------------

// File: rtl/wall_map_if.sv
// Destroy handshake between the explosion logic and the tile map.
// The requester holds req, col and row until it sees ack.
interface wall_map_if;
    logic       destroy_req;
    logic [4:0] destroy_col;
    logic [3:0] destroy_row;
    logic       destroy_ack;
    logic       destroy_hit;

    modport master (
        output destroy_req, destroy_col, destroy_row,
        input  destroy_ack, destroy_hit
    );

    modport slave (
        input  destroy_req, destroy_col, destroy_row,
        output destroy_ack, destroy_hit
    );
endinterface

// File: rtl/wall_map.sv
// Tile-map store and sequencer feeding the wall sprite renderer.
// Fills the arena after reset, services brick hits, animates crumbling.
module wall_map #(
    parameter int COLS     = 20,
    parameter int ROWS     = 15,
    parameter int ANIM_DIV = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [10:0] spotX,
    input  logic signed [10:0] spotY,
    input  logic               frame_tick,
    wall_map_if.slave          dif,
    output logic [9:0]         wall_centerX,
    output logic [9:0]         wall_centerY,
    output logic [3:0]         sprite_num,
    output logic               init_done
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_D_RD, S_D_WR, S_D_GAP, S_A_RD, S_A_WR
    } state_t;

    logic [3:0]    mem [DEPTH];

    state_t        state_q, state_d;
    logic [4:0]    col_q, col_d, nxt_col;
    logic [3:0]    row_q, row_d, nxt_row;
    logic          done_q, done_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    rdata_q, rdata_d;
    logic [9:0]    cx_q, cx_d, cy_q, cy_d;
    logic [3:0]    spr_q, spr_d;

    logic [AW-1:0] addr, r_addr;
    logic          last, oob, r_ok, we, ack, hit;
    logic [3:0]    wdata, init_code;
    int            pos_sum;

    // FSM cursor: linear address, wrap detection, next tile in scan order
    always_comb begin
        addr    = AW'(int'(row_q) * COLS + int'(col_q));
        last    = (int'(col_q) == COLS - 1) && (int'(row_q) == ROWS - 1);
        oob     = (int'(col_q) >= COLS) || (int'(row_q) >= ROWS);
        nxt_col = col_q + 5'd1;
        nxt_row = row_q;
        if (int'(col_q) == COLS - 1) begin
            nxt_col = '0;
            nxt_row = row_q + 4'd1;
        end
    end

    // Arena layout: border and even/even pillars, clear spawn corners, brick checkerboard
    always_comb begin
        pos_sum   = int'(col_q) + int'(row_q);
        init_code = 4'd0;
        if (row_q == '0 || int'(row_q) == ROWS - 1 ||
            col_q == '0 || int'(col_q) == COLS - 1 ||
            (!col_q[0] && !row_q[0])) begin
            init_code = 4'd1;
        end else if (pos_sum <= 4 || pos_sum >= COLS + ROWS - 6) begin
            init_code = 4'd0;
        end else if (col_q[0] ^ row_q[0]) begin
            init_code = 4'd2;
        end
    end

    // Sequencer: init fill, destroy service, crumble sweep, frame divider
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = done_q;
        pend_d  = pend_q;
        div_d   = div_q;
        rdata_d = rdata_q;
        we      = 1'b0;
        wdata   = 4'd0;
        ack     = 1'b0;
        hit     = 1'b0;
        unique case (state_q)
            S_INIT: begin
                we    = 1'b1;
                wdata = init_code;
                if (last) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    col_d = nxt_col;
                    row_d = nxt_row;
                end
            end
            S_IDLE: begin
                if (dif.destroy_req) begin
                    col_d   = dif.destroy_col;
                    row_d   = dif.destroy_row;
                    state_d = S_D_RD;
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_A_RD;
                end
            end
            S_D_RD: begin
                if (!oob) rdata_d = mem[addr];
                state_d = S_D_WR;
            end
            S_D_WR: begin
                ack     = 1'b1;
                state_d = S_D_GAP;
                if (oob) begin
                    hit = 1'b1;
                end else begin
                    hit = (rdata_q != 4'd0);
                    if (rdata_q == 4'd2) begin
                        we    = 1'b1;
                        wdata = 4'd3;
                    end
                end
            end
            S_D_GAP: begin
                state_d = S_IDLE;
            end
            S_A_RD: begin
                rdata_d = mem[addr];
                state_d = S_A_WR;
            end
            S_A_WR: begin
                if (rdata_q >= 4'd3 && rdata_q <= 4'd5) begin
                    we    = 1'b1;
                    wdata = rdata_q + 4'd1;
                end else if (rdata_q == 4'd6) begin
                    we    = 1'b1;
                    wdata = 4'd0;
                end
                if (last) begin
                    state_d = S_IDLE;
                end else begin
                    col_d   = nxt_col;
                    row_d   = nxt_row;
                    state_d = S_A_RD;
                end
            end
            default: state_d = S_INIT;
        endcase
        // A divided tick wins over the clear so it is not lost at sweep start
        if (frame_tick) begin
            if (div_q == DW'(ANIM_DIV - 1)) begin
                div_d  = '0;
                pend_d = 1'b1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    // Render lookup: tile origin and code under the spot, blanked until filled
    always_comb begin
        r_ok   = (int'(spotX) >= 0) && (int'(spotX) < COLS * 32) &&
                 (int'(spotY) >= 0) && (int'(spotY) < ROWS * 32);
        r_addr = AW'(int'(spotY[8:5]) * COLS + int'(spotX[9:5]));
        cx_d   = '0;
        cy_d   = '0;
        spr_d  = '0;
        if (done_q && r_ok) begin
            cx_d  = {spotX[9:5], 5'b0};
            cy_d  = {1'b0, spotY[8:5], 5'b0};
            spr_d = mem[r_addr];
        end
    end

    // FSM-owned write port; contents are rebuilt by the fill after every reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
            div_q   <= '0;
            rdata_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            spr_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            div_q   <= div_d;
            rdata_q <= rdata_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            spr_q   <= spr_d;
        end
    end

    assign wall_centerX    = cx_q;
    assign wall_centerY    = cy_q;
    assign sprite_num      = spr_q;
    assign init_done       = done_q;
    assign dif.destroy_ack = ack;
    assign dif.destroy_hit = hit;
endmodule

// File: tb/tb_wall_map.sv
// Bench for wall_map: behavioural map model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wall_map;
    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic signed [10:0] spotX = '0;
    logic signed [10:0] spotY = '0;
    logic               frame_tick = 1'b0;
    logic [9:0]         wcx, wcy;
    logic [3:0]         spr;
    logic               idone;
    bit                 rnd_en = 1'b0;
    int                 tests = 0;
    int                 fails = 0;
    int                 ack_cnt = 0;

    wall_map_if dif();

    wall_map dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spotX        (spotX),
        .spotY        (spotY),
        .frame_tick   (frame_tick),
        .dif          (dif),
        .wall_centerX (wcx),
        .wall_centerY (wcy),
        .sprite_num   (spr),
        .init_done    (idone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [3:0]   m_map [300];
    int         m_mode = 0;
    int         m_t = 0;
    int         m_cnt = 0;
    bit         m_pend = 0;
    bit         m_done = 0;
    bit         m_dhit = 0;
    bit         m_dwr = 0;
    int         m_didx = 0;
    logic [9:0] e_cx = '0;
    logic [9:0] e_cy = '0;
    logic [3:0] e_spr = '0;
    bit         e_ack = 0;
    bit         e_hit = 0;

    function automatic bit [3:0] arena(input int c, input int r);
        if (r == 0 || r == 14 || c == 0 || c == 19 || (c % 2 == 0 && r % 2 == 0)) return 4'd1;
        if ((c - 1) + (r - 1) <= 2 || (18 - c) + (13 - r) <= 2) return 4'd0;
        if ((c + r) % 2 == 1) return 4'd2;
        return 4'd0;
    endfunction

    // modes: 0 fill, 1 idle, 2 destroy (3 cycles), 3 sweep (600 cycles)
    always @(posedge clk or negedge reset_n) begin : mdl
        int x, y, k, c, r;
        if (!reset_n) begin
            m_mode = 0; m_t = 0; m_cnt = 0; m_pend = 0; m_done = 0;
            e_cx = '0; e_cy = '0; e_spr = '0; e_ack = 0; e_hit = 0;
        end else begin
            x = spotX;
            y = spotY;
            if (m_done && x >= 0 && x < 640 && y >= 0 && y < 480) begin
                e_cx  = 10'((x / 32) * 32);
                e_cy  = 10'((y / 32) * 32);
                e_spr = m_map[(y / 32) * 20 + x / 32];
            end else begin
                e_cx = '0; e_cy = '0; e_spr = '0;
            end
            case (m_mode)
                0: begin
                    m_map[m_t] = arena(m_t % 20, m_t / 20);
                    if (m_t == 299) begin m_done = 1; m_mode = 1; end
                    else m_t++;
                end
                1: begin
                    if (dif.destroy_req) begin m_mode = 2; m_t = 0; end
                    else if (m_pend) begin m_pend = 0; m_mode = 3; m_t = 0; end
                end
                2: begin
                    if (m_t == 1 && m_dwr) m_map[m_didx] = 4'd3;
                    if (m_t == 2) m_mode = 1;
                    else m_t++;
                end
                default: begin
                    if (m_t % 2 == 1) begin
                        k = m_t / 2;
                        c = m_map[k];
                        if (c >= 3 && c <= 5) m_map[k] = 4'(c + 1);
                        else if (c == 6) m_map[k] = 4'd0;
                    end
                    if (m_t == 599) m_mode = 1;
                    else m_t++;
                end
            endcase
            if (frame_tick) begin
                m_cnt++;
                if (m_cnt == 8) begin m_cnt = 0; m_pend = 1; end
            end
            e_ack = (m_mode == 2 && m_t == 1);
            if (e_ack) begin
                c = dif.destroy_col;
                r = dif.destroy_row;
                if (c >= 20 || r >= 15) begin
                    m_dhit = 1; m_dwr = 0;
                end else begin
                    m_didx = r * 20 + c;
                    m_dhit = (m_map[m_didx] != 0);
                    m_dwr  = (m_map[m_didx] == 2);
                end
            end
            e_hit = e_ack ? m_dhit : 1'b0;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        chk("sprite_num", spr, e_spr);
        chk("centerX", wcx, e_cx);
        chk("centerY", wcy, e_cy);
        chk("init_done", idone, m_done);
        chk("ack", dif.destroy_ack, e_ack);
        chk("hit", dif.destroy_hit, e_hit);
        if (dif.destroy_ack === 1'b1) ack_cnt++;
    end

    // random spot / frame_tick driver
    always @(posedge clk) begin : rnd
        int v;
        if (rnd_en) begin
            #1;
            v = int'($urandom_range(0, 719)) - 40;
            spotX = 11'(v);
            v = int'($urandom_range(0, 539)) - 30;
            spotY = 11'(v);
            frame_tick = ($urandom_range(0, 29) == 0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (n < 1000) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (idone === 1'b1) break;
        end
        chk(name, n, 300);
    endtask

    task automatic peek(input int c, input int r, output logic [3:0] v);
        spotX = 11'(c * 32 + 5);
        spotY = 11'(r * 32 + 5);
        step();
        v = spr;
    endtask

    task automatic destroy(input int c, input int r, output logic hit, output int lat);
        dif.destroy_col = 5'(c);
        dif.destroy_row = 4'(r);
        dif.destroy_req = 1'b1;
        lat = 0;
        hit = 1'b0;
        while (lat < 2000) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (dif.destroy_ack === 1'b1) break;
        end
        if (lat >= 2000) chk("destroy_timeout", 0, 1);
        hit = dif.destroy_hit;
        step();
        dif.destroy_req = 1'b0;
    endtask

    task automatic tick(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            repeat (gap) step();
        end
    endtask

    logic [3:0] v;
    logic       h;
    int         lat;
    int         a0;

    initial begin
        logic [3:0] exp_seq [4];
        int         cells [8][3];
        exp_seq = '{4'd4, 4'd5, 4'd6, 4'd0};
        cells = '{'{0, 0, 1}, '{2, 2, 1}, '{3, 2, 2}, '{1, 1, 0},
                  '{2, 1, 0}, '{1, 2, 0}, '{18, 13, 0}, '{19, 14, 1}};
        dif.destroy_req = 1'b0;
        dif.destroy_col = '0;
        dif.destroy_row = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sprite", spr, 0);
        chk("rst_centerX", wcx, 0);
        chk("rst_init_done", idone, 0);
        chk("rst_ack", dif.destroy_ack, 0);
        reset_n = 1'b1;
        wait_init("init_latency");

        for (int i = 0; i < 8; i++) begin
            peek(cells[i][0], cells[i][1], v);
            chk($sformatf("map(%0d,%0d)", cells[i][0], cells[i][1]), v, cells[i][2]);
        end

        spotX = 11'sd100; spotY = 11'sd70;
        @(negedge clk);
        chk("latency_pre_cx", wcx, 608);
        step();
        chk("render_cx", wcx, 96);
        chk("render_cy", wcy, 64);
        chk("render_spr", spr, 2);
        spotX = -11'sd5; spotY = 11'sd10; step();
        chk("neg_x_spr", spr, 0);
        chk("neg_x_cx", wcx, 0);
        spotX = 11'sd640; step();
        chk("x640_spr", spr, 0);
        chk("x640_cy", wcy, 0);
        spotX = 11'sd639; spotY = 11'sd479; step();
        chk("corner_cx", wcx, 608);
        chk("corner_cy", wcy, 448);
        chk("corner_spr", spr, 1);

        destroy(3, 2, h, lat);
        chk("d32_hit", h, 1);
        chk("d32_lat", lat, 2);
        peek(3, 2, v); chk("d32_tile", v, 3);
        destroy(3, 2, h, lat);
        chk("d32b_hit", h, 1);
        peek(3, 2, v); chk("d32b_tile", v, 3);
        destroy(1, 1, h, lat);
        chk("d11_hit", h, 0);
        destroy(25, 3, h, lat);
        chk("doob_hit", h, 1);

        // one crumble step, then reset in the middle of the next sweep
        tick(8, 5);
        repeat (700) step();
        peek(3, 2, v); chk("anim_first", v, 4);
        tick(8, 5);
        repeat (40) step();
        chk("pre_reset_spr", spr, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_spr", spr, 0);
        chk("async_rst_cx", wcx, 0);
        chk("async_rst_cy", wcy, 0);
        chk("async_rst_done", idone, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_init("reinit_latency");
        peek(3, 2, v); chk("refill_32", v, 2);

        destroy(3, 2, h, lat);
        chk("d32c_hit", h, 1);
        for (int i = 0; i < 4; i++) begin
            tick(8, 5);
            repeat (700) step();
            peek(3, 2, v);
            chk($sformatf("anim_step%0d", i), v, exp_seq[i]);
        end
        destroy(3, 2, h, lat);
        chk("crumbled_hit", h, 0);

        // destroy arriving in the third cycle of a sweep waits for it
        tick(7, 5);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (3) step();
        a0 = ack_cnt;
        destroy(5, 2, h, lat);
        chk("sweep_wait_lat", lat, 600);
        chk("sweep_wait_hit", h, 1);
        repeat (20) step();
        chk("single_ack", ack_cnt - a0, 1);
        peek(5, 2, v); chk("sweep_wait_tile", v, 3);

        // random traffic against the model
        rnd_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 40)) step();
            destroy(int'($urandom_range(0, 23)), int'($urandom_range(0, 15)), h, lat);
        end
        rnd_en = 1'b0;
        step();
        frame_tick = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
